// File: rtl/dsp_mac_sequencer.sv
// Streaming dot-product sequencer for one DSP48A1 slice: accepts a job length, feeds
// operand pairs into the slice, waits out its pipeline, then returns P on a valid/ready port.
module dsp_mac_sequencer #(
  parameter int LEN_W   = 8,
  parameter int DSP_LAT = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_job_valid,
  input  logic [LEN_W-1:0]   i_job_len,
  output logic               o_job_ready,
  input  logic               i_abort,
  input  logic               i_s_valid,
  input  logic [17:0]        i_s_a,
  input  logic [17:0]        i_s_b,
  output logic               o_s_ready,
  output logic               o_res_valid,
  output logic [47:0]        o_res_data,
  input  logic               i_res_ready,
  output logic               o_busy,
  output logic [17:0]        o_dsp_a,
  output logic [17:0]        o_dsp_b,
  output logic               o_dsp_cea,
  output logic               o_dsp_cem,
  output logic               o_dsp_cep,
  output logic [7:0]         o_dsp_opmode,
  output logic               o_dsp_ceopmode,
  output logic               o_dsp_rstp,
  input  logic [47:0]        i_dsp_p
);

  localparam int PW = DSP_LAT - 1;
  // Every stage except the last still owes a P update after the current edge.
  localparam logic [PW-1:0] C_EARLY_MASK = {PW{1'b1}} >> 1;
  localparam logic [7:0]    C_OPMODE     = 8'b0000_1001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [PW-1:0]    r_vpipe;
  logic             w_job_hs;
  logic             w_s_hs;
  logic             w_abort;
  logic             w_pending;

  // Next-state logic and all handshake/slice-control outputs.
  always_comb begin
    w_next         = r_state;
    w_job_hs       = 1'b0;
    w_s_hs         = 1'b0;
    w_abort        = 1'b0;
    w_pending      = |(r_vpipe & C_EARLY_MASK);
    o_job_ready    = 1'b0;
    o_s_ready      = 1'b0;
    o_res_valid    = 1'b0;
    o_res_data     = 48'd0;
    o_busy         = 1'b0;
    o_dsp_a        = 18'd0;
    o_dsp_b        = 18'd0;
    o_dsp_cea      = 1'b0;
    o_dsp_cem      = 1'b0;
    o_dsp_cep      = 1'b0;
    o_dsp_opmode   = 8'd0;
    o_dsp_ceopmode = 1'b0;
    o_dsp_rstp     = 1'b1;
    if (i_rst) begin
      w_next = S_IDLE;
    end else begin
      w_abort        = (r_state != S_IDLE) && i_abort;
      o_job_ready    = (r_state == S_IDLE);
      w_job_hs       = o_job_ready && i_job_valid;
      o_s_ready      = (r_state == S_RUN) && (r_cnt < r_len) && !i_abort;
      w_s_hs         = o_s_ready && i_s_valid;
      o_res_valid    = (r_state == S_DONE) && !i_abort;
      o_res_data     = o_res_valid ? i_dsp_p : 48'd0;
      o_busy         = (r_state != S_IDLE);
      o_dsp_a        = i_s_a;
      o_dsp_b        = i_s_b;
      o_dsp_cea      = w_s_hs;
      o_dsp_cem      = 1'b1;
      o_dsp_cep      = r_vpipe[PW-1];
      o_dsp_opmode   = C_OPMODE;
      o_dsp_ceopmode = 1'b1;
      o_dsp_rstp     = w_job_hs || w_abort;
      case (r_state)
        S_IDLE: begin
          if (w_job_hs) w_next = S_RUN;
          else          w_next = S_IDLE;
        end
        S_RUN: begin
          // Skip DRAIN when nothing is left in flight (e.g. a zero-length job).
          if (r_cnt == r_len) w_next = w_pending ? S_DRAIN : S_DONE;
          else                w_next = S_RUN;
        end
        S_DRAIN: begin
          if (!w_pending) w_next = S_DONE;
          else            w_next = S_DRAIN;
        end
        S_DONE: begin
          if (i_res_ready) w_next = S_IDLE;
          else             w_next = S_DONE;
        end
        default: w_next = S_IDLE;
      endcase
      if (w_abort) w_next = S_IDLE;
      else         w_next = w_next;
    end
  end

  // State, job counters and the operand-valid pipe that mirrors the slice's A/M stages.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_len   <= {LEN_W{1'b0}};
      r_cnt   <= {LEN_W{1'b0}};
      r_vpipe <= {PW{1'b0}};
    end else begin
      r_state <= w_next;
      if (w_job_hs) begin
        r_len <= i_job_len;
        r_cnt <= {LEN_W{1'b0}};
      end else if (w_s_hs) begin
        r_len <= r_len;
        r_cnt <= r_cnt + LEN_W'(1'b1);
      end else begin
        r_len <= r_len;
        r_cnt <= r_cnt;
      end
      if (w_abort) r_vpipe <= {PW{1'b0}};
      else         r_vpipe <= (r_vpipe << 1) | PW'(w_s_hs);
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural DSP48A1 slice
// (A/B, M and P registers, RSTP clear) closing the loop on P.
module tb_dsp_mac_sequencer;

  logic        clk;
  logic        rst;
  logic        job_valid;
  logic [7:0]  job_len;
  logic        job_ready;
  logic        abort_i;
  logic        s_valid;
  logic [17:0] s_a;
  logic [17:0] s_b;
  logic        s_ready;
  logic        res_valid;
  logic [47:0] res_data;
  logic        res_ready;
  logic        busy;
  logic [17:0] dsp_a;
  logic [17:0] dsp_b;
  logic        dsp_cea;
  logic        dsp_cem;
  logic        dsp_cep;
  logic [7:0]  dsp_opmode;
  logic        dsp_ceopmode;
  logic        dsp_rstp;
  logic [47:0] dsp_p;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic signed [17:0] va [8];
  logic signed [17:0] vb [8];

  dsp_mac_sequencer #(.LEN_W(8), .DSP_LAT(3)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_job_valid(job_valid), .i_job_len(job_len), .o_job_ready(job_ready),
    .i_abort(abort_i),
    .i_s_valid(s_valid), .i_s_a(s_a), .i_s_b(s_b), .o_s_ready(s_ready),
    .o_res_valid(res_valid), .o_res_data(res_data), .i_res_ready(res_ready),
    .o_busy(busy),
    .o_dsp_a(dsp_a), .o_dsp_b(dsp_b),
    .o_dsp_cea(dsp_cea), .o_dsp_cem(dsp_cem), .o_dsp_cep(dsp_cep),
    .o_dsp_opmode(dsp_opmode), .o_dsp_ceopmode(dsp_ceopmode),
    .o_dsp_rstp(dsp_rstp), .i_dsp_p(dsp_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural DSP48A1 slice: A1/B1 -> M -> P, OPMODE fixed at X=M, Z=P.
  logic signed [17:0] m_a;
  logic signed [17:0] m_b;
  logic signed [35:0] m_prod;
  logic [47:0]        m_m;
  logic [47:0]        m_p;
  assign m_prod = m_a * m_b;
  assign dsp_p  = m_p;

  always @(posedge clk) begin
    if (dsp_rstp) begin
      m_a <= 18'sd0;
      m_b <= 18'sd0;
      m_m <= 48'd0;
      m_p <= 48'd0;
    end else begin
      if (dsp_cea) begin
        m_a <= dsp_a;
        m_b <= dsp_b;
      end
      if (dsp_cem) m_m <= {{12{m_prod[35]}}, m_prod};
      if (dsp_cep) m_p <= m_p + m_m;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      job_valid = 1'($urandom);
      job_len   = 8'($urandom);
      abort_i   = 1'($urandom);
      s_valid   = 1'($urandom);
      s_a       = 18'($urandom);
      s_b       = 18'($urandom);
      res_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({job_ready, s_ready, res_valid, busy, dsp_cea, dsp_cem, dsp_cep, dsp_ceopmode} !== 8'h00) begin
        failures++;
        $display("FAIL reset_ctl cycle %0d: got %b expected 00000000", c,
                 {job_ready, s_ready, res_valid, busy, dsp_cea, dsp_cem, dsp_cep, dsp_ceopmode});
      end
      checks++;
      if ({res_data, dsp_a, dsp_b, dsp_opmode} !== 92'd0) begin
        failures++;
        $display("FAIL reset_data cycle %0d: res_data=%h a=%h b=%h opmode=%h expected all 0",
                 c, res_data, dsp_a, dsp_b, dsp_opmode);
      end
      checks++;
      if (dsp_rstp !== 1'b1) begin
        failures++;
        $display("FAIL reset_rstp cycle %0d: got %b expected 1", c, dsp_rstp);
      end
      next_cycle();
    end
    checks++;
    if (m_p !== 48'd0) begin
      failures++;
      $display("FAIL reset_p: got %h expected 0", m_p);
    end
    rst = 1'b0; job_valid = 1'b0; job_len = 8'd0; abort_i = 1'b0;
    s_valid = 1'b0; s_a = 18'd0; s_b = 18'd0; res_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({job_ready, busy, s_ready, dsp_cem, dsp_ceopmode, dsp_opmode} !== {5'b10011, 8'h09}) begin
      failures++;
      $display("FAIL idle_out: got %b expected 10011_00001001",
               {job_ready, busy, s_ready, dsp_cem, dsp_ceopmode, dsp_opmode});
    end
    next_cycle();
  endtask

  task automatic run_job(input string name, input int len, input int gap, input int hold,
                         input logic [47:0] exp_sum);
    int hs_cyc;
    int last_acc;
    int got_cyc;
    bit found;
    job_valid = 1'b1;
    job_len   = 8'(len);
    @(negedge clk);
    checks++;
    if ({job_ready, dsp_rstp} !== 2'b11) begin
      failures++;
      $display("FAIL %s job_hs: ready/rstp=%b expected 11", name, {job_ready, dsp_rstp});
    end
    hs_cyc   = cyc;
    last_acc = cyc;
    next_cycle();
    job_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      for (int g = 0; g < gap; g++) begin
        s_valid = 1'b0;
        next_cycle();
      end
      s_valid = 1'b1;
      s_a     = va[i];
      s_b     = vb[i];
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b1) begin
        failures++;
        $display("FAIL %s s_ready[%0d]: got %b expected 1", name, i, s_ready);
      end
      last_acc = cyc;
      next_cycle();
    end
    s_valid = 1'b0;
    found   = 1'b0;
    got_cyc = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        found   = 1'b1;
        got_cyc = cyc;
        break;
      end
      next_cycle();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL %s res_timeout: res_valid never rose, expected 1", name);
    end else begin
      checks++;
      if (len > 0 && got_cyc - last_acc != 3) begin
        failures++;
        $display("FAIL %s latency: got %0d cycles expected 3", name, got_cyc - last_acc);
      end else if (len == 0 && got_cyc - hs_cyc != 2) begin
        failures++;
        $display("FAIL %s latency0: got %0d cycles expected 2", name, got_cyc - hs_cyc);
      end
      checks++;
      if (res_data !== exp_sum) begin
        failures++;
        $display("FAIL %s res_data: got %h expected %h", name, res_data, exp_sum);
      end
      for (int h = 0; h < hold; h++) begin
        next_cycle();
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== exp_sum) begin
          failures++;
          $display("FAIL %s hold[%0d]: valid=%b data=%h expected 1/%h",
                   name, h, res_valid, res_data, exp_sum);
        end
      end
      res_ready = 1'b1;
      next_cycle();
      res_ready = 1'b0;
      @(negedge clk);
      checks++;
      if ({res_valid, busy, job_ready} !== 3'b001 || res_data !== 48'd0) begin
        failures++;
        $display("FAIL %s consume: valid/busy/jready=%b data=%h expected 001/0",
                 name, {res_valid, busy, job_ready}, res_data);
      end
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    va[0] = 18'sd5;  vb[0] = 18'sd6;
    va[1] = 18'sd20; vb[1] = 18'sd10;
    va[2] = -18'sd3; vb[2] = 18'sd4;
    run_job("b2b", 3, 0, 0, 48'h0000_0000_00DA);
  endtask

  task automatic test_gaps();
    run_job("gaps", 3, 2, 5, 48'h0000_0000_00DA);
  endtask

  task automatic test_len_zero();
    run_job("len0", 0, 0, 0, 48'd0);
    va[0] = -18'sd131072; vb[0] = -18'sd131072;
    run_job("minmin", 1, 0, 0, 48'h0004_0000_0000);
  endtask

  task automatic test_abort();
    bit seen;
    va[0] = 18'sd100; vb[0] = 18'sd100;
    va[1] = 18'sd50;  vb[1] = 18'sd50;
    job_valid = 1'b1;
    job_len   = 8'd4;
    next_cycle();
    job_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_a = va[i]; s_b = vb[i];
      next_cycle();
    end
    abort_i = 1'b1;
    s_a = 18'sd9; s_b = 18'sd9;
    @(negedge clk);
    checks++;
    if ({s_ready, dsp_cea, dsp_rstp} !== 3'b001) begin
      failures++;
      $display("FAIL abort_cycle: s_ready/cea/rstp=%b expected 001", {s_ready, dsp_cea, dsp_rstp});
    end
    next_cycle();
    abort_i = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, job_ready} !== 2'b01) begin
      failures++;
      $display("FAIL abort_idle: busy/job_ready=%b expected 01", {busy, job_ready});
    end
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      @(negedge clk);
      if (res_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL abort_nores: res_valid got 1 expected 0");
    end
    next_cycle();
    va[0] = 18'sd7; vb[0] = 18'sd3;
    run_job("after_abort", 1, 0, 0, 48'd21);
  endtask

  task automatic test_reset_mid_job();
    job_valid = 1'b1;
    job_len   = 8'd4;
    next_cycle();
    job_valid = 1'b0;
    s_valid = 1'b1; s_a = 18'sd11; s_b = 18'sd13;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_ready, busy, res_valid, dsp_rstp, job_ready} !== 5'b00010) begin
      failures++;
      $display("FAIL rst_mid: s_ready/busy/rv/rstp/jr=%b expected 00010",
               {s_ready, busy, res_valid, dsp_rstp, job_ready});
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_ready, busy, job_ready} !== 3'b001) begin
      failures++;
      $display("FAIL rst_idle: s_ready/busy/jr=%b expected 001", {s_ready, busy, job_ready});
    end
    next_cycle();
    s_valid = 1'b0;
    va[0] = 18'sd1; vb[0] = 18'sd1;
    va[1] = 18'sd2; vb[1] = 18'sd2;
    run_job("after_rst", 2, 0, 0, 48'd5);
  endtask

  initial begin
    rst = 1'b1; job_valid = 1'b0; job_len = 8'd0; abort_i = 1'b0;
    s_valid = 1'b0; s_a = 18'd0; s_b = 18'd0; res_ready = 1'b0;
    #1;
    test_reset();
    test_back_to_back();
    test_gaps();
    test_len_zero();
    test_abort();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
